// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin priority arbiter.
package arb_pkg;

    localparam int ARB_MAX_N = 32;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pri_pick.sv
// Rotating priority encoder: first set req bit at or above ptr, wrapping N-1 -> 0.
module rr_pri_pick #(
    parameter int N  = 8,
    parameter int IW = 3
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  pick,
    output logic [IW-1:0] pick_idx,
    output logic          any
);

    int unsigned j;

    always_comb begin
        pick     = '0;
        pick_idx = '0;
        any      = 1'b0;
        j        = 0;
        for (int unsigned k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (!any && req[j]) begin
                any      = 1'b1;
                pick[j]  = 1'b1;
                pick_idx = IW'(j);
            end
        end
    end

endmodule

// File: rtl/rr_pri_arbiter.sv
// Round-robin arbiter with held, registered grant released by done.
// Optional forced release after MAX_HOLD cycles when ARB_TIMEOUT_EN is defined.
module rr_pri_arbiter
    import arb_pkg::*;
#(
    parameter  int N        = 8,
    parameter  int MAX_HOLD = 16,
    localparam int IW       = idx_width(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          done,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_valid
`ifdef ARB_TIMEOUT_EN
    ,
    output logic          timeout
`endif
);

    if (N < 2 || N > ARB_MAX_N || MAX_HOLD < 1 || MAX_HOLD > 65535) begin : g_bad_param
        $error("rr_pri_arbiter: parameter out of range");
    end

    arb_state_e    state_q;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [N-1:0]  gnt_q;
    logic [IW-1:0] idx_q;
    logic          valid_q;
    logic          rel;
    logic          expire;
    logic [N-1:0]  pick;
    logic [IW-1:0] pick_idx;
    logic          any;
`ifdef ARB_TIMEOUT_EN
    logic [15:0]   hold_q;
    logic          timeout_q;
`endif

    always_comb begin
        rel    = 1'b0;
        expire = 1'b0;
        if (state_q == ARB_GRANT) begin
`ifdef ARB_TIMEOUT_EN
            expire = !done && (hold_q == 16'(MAX_HOLD - 1));
`endif
            rel = done || expire;
        end
        // The picker sees the post-release pointer so the outgoing owner ranks last.
        ptr_d = ptr_q;
        if (rel) ptr_d = (idx_q == IW'(N - 1)) ? '0 : idx_q + 1'b1;
    end

    rr_pri_pick #(.N(N), .IW(IW)) u_pick (
        .req      (req),
        .ptr      (ptr_d),
        .pick     (pick),
        .pick_idx (pick_idx),
        .any      (any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ARB_IDLE;
            ptr_q     <= '0;
            gnt_q     <= '0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            hold_q    <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                ARB_IDLE: begin
`ifdef ARB_TIMEOUT_EN
                    timeout_q <= 1'b0;
                    hold_q    <= '0;
`endif
                    if (any) begin
                        gnt_q   <= pick;
                        idx_q   <= pick_idx;
                        valid_q <= 1'b1;
                        state_q <= ARB_GRANT;
                    end
                end
                ARB_GRANT: begin
                    if (rel) begin
                        ptr_q   <= ptr_d;
                        gnt_q   <= pick;
                        idx_q   <= pick_idx;
                        valid_q <= any;
                        state_q <= any ? ARB_GRANT : ARB_IDLE;
`ifdef ARB_TIMEOUT_EN
                        hold_q    <= '0;
                        timeout_q <= expire;
`endif
                    end else begin
`ifdef ARB_TIMEOUT_EN
                        hold_q    <= hold_q + 16'd1;
                        timeout_q <= 1'b0;
`endif
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = idx_q;
    assign gnt_valid = valid_q;
`ifdef ARB_TIMEOUT_EN
    assign timeout   = timeout_q;
`endif

endmodule

// File: tb/tb_rr_pri_arbiter.sv
// Self-checking bench for rr_pri_arbiter: directed table, corner sequences, random vs. model.
module tb_rr_pri_arbiter;

    localparam int N = 8;
`ifdef ARB_TIMEOUT_EN
    localparam int TB_MAX_HOLD = 4;
`else
    localparam int TB_MAX_HOLD = 16;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] req;
    logic         done;
    logic [N-1:0] gnt;
    logic [2:0]   gnt_idx;
    logic         gnt_valid;
`ifdef ARB_TIMEOUT_EN
    logic         timeout;
`endif

    always #5 clk = ~clk;

    rr_pri_arbiter #(.N(N), .MAX_HOLD(TB_MAX_HOLD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
`ifdef ARB_TIMEOUT_EN
        ,
        .timeout   (timeout)
`endif
    );

    int errors = 0;
    int checks = 0;

    // Reference model: who owns the grant, where the search starts, how long it has been held.
    int m_owner;
    int m_ptr;
    int m_hold;
    int m_to;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int first_from(input logic [N-1:0] r, input int start);
        for (int i = 0; i < N; i++) begin
            if (r[(start + i) % N]) return (start + i) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_hold  = 0;
        m_to    = 0;
    endtask

    task automatic model_update(input logic [N-1:0] r, input logic d);
        bit expired;
        if (m_owner < 0) begin
            m_to    = 0;
            m_owner = first_from(r, m_ptr);
            m_hold  = 0;
        end else begin
            expired = 1'b0;
`ifdef ARB_TIMEOUT_EN
            expired = !d && (m_hold == TB_MAX_HOLD - 1);
`endif
            if (d || expired) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = first_from(r, m_ptr);
                m_hold  = 0;
                m_to    = expired ? 1 : 0;
            end else begin
                m_hold++;
                m_to = 0;
            end
        end
    endtask

    task automatic compare_model();
        logic [N-1:0] eg;
        eg = (m_owner >= 0) ? N'(1 << m_owner) : '0;
        check("model_gnt", 32'(gnt), 32'(eg));
        check("model_idx", 32'(gnt_idx), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
        check("model_valid", 32'(gnt_valid), (m_owner >= 0) ? 32'd1 : 32'd0);
        check("onehot0", 32'($onehot0(gnt)), 32'd1);
        check("valid_eq_or", 32'(gnt_valid), 32'(|gnt));
`ifdef ARB_TIMEOUT_EN
        check("model_timeout", 32'(timeout), 32'(m_to));
`endif
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic step(input logic [N-1:0] r, input logic d);
        req  = r;
        done = d;
        @(posedge clk);
        model_update(r, d);
        #1;
        compare_model();
        @(negedge clk);
    endtask

    typedef struct {
        logic [N-1:0] req;
        logic         done;
        logic         valid;
        logic [2:0]   idx;
    } vec_t;

    vec_t tbl[64];
    int   nv = 0;

    task automatic add(input logic [N-1:0] r, input logic d, input logic v, input logic [2:0] i);
        tbl[nv] = '{req: r, done: d, valid: v, idx: i};
        nv++;
    endtask

    initial begin
        model_reset();
        rst_n = 1'b0;
        req   = '0;
        done  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // reset state
        for (int k = 0; k < 3; k++) add(8'h00, 1'b0, 1'b0, 3'd0);
        // single request, held 4 cycles, released with req low
        add(8'h20, 1'b0, 1'b1, 3'd5);
        for (int k = 0; k < 3; k++) add(8'h00, 1'b0, 1'b1, 3'd5);
        add(8'h00, 1'b1, 1'b0, 3'd0);
        // fairness from ptr=6 with all requesting, no bubbles
        add(8'hFF, 1'b0, 1'b1, 3'd6);
        add(8'hFF, 1'b1, 1'b1, 3'd7);
        for (int k = 0; k < 8; k++) add(8'hFF, 1'b1, 1'b1, 3'(k));
        add(8'hFF, 1'b1, 1'b1, 3'd0);
        add(8'h00, 1'b1, 1'b0, 3'd0);
        // wrap and skip: owner 6 releases with req=1000_0001
        add(8'h40, 1'b0, 1'b1, 3'd6);
        add(8'h81, 1'b1, 1'b1, 3'd7);
        add(8'h81, 1'b1, 1'b1, 3'd0);
        add(8'h00, 1'b1, 1'b0, 3'd0);
        // done in IDLE ignored; lone requester re-granted back-to-back
        add(8'h00, 1'b1, 1'b0, 3'd0);
        for (int k = 0; k < 3; k++) add(8'h04, 1'b1, 1'b1, 3'd2);
        add(8'h00, 1'b1, 1'b0, 3'd0);

        for (int v = 0; v < nv; v++) begin
            step(tbl[v].req, tbl[v].done);
            check("tbl_valid", 32'(gnt_valid), 32'(tbl[v].valid));
            check("tbl_idx", 32'(gnt_idx), 32'(tbl[v].idx));
        end

        // async reset mid-grant, between edges
        step(8'h08, 1'b0);
        check("pre_rst_idx", 32'(gnt_idx), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("async_gnt", 32'(gnt), 32'd0);
        check("async_valid", 32'(gnt_valid), 32'd0);
        check("async_idx", 32'(gnt_idx), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(8'h80, 1'b0);
        check("post_rst_idx", 32'(gnt_idx), 32'd7);
        step(8'h80, 1'b1);
        check("wrap_regrant", 32'(gnt_idx), 32'd7);
        step(8'h00, 1'b1);
        check("wrap_release", 32'(gnt_valid), 32'd0);

`ifdef ARB_TIMEOUT_EN
        for (int k = 0; k < 5; k++) begin
            step(8'h03, 1'b0);
            check("to_idx", 32'(gnt_idx), (k == 4) ? 32'd1 : 32'd0);
            check("to_pulse", 32'(timeout), (k == 4) ? 32'd1 : 32'd0);
        end
        for (int k = 0; k < 3; k++) step(8'h03, 1'b0);
        step(8'h03, 1'b1);
        check("to_done_same", 32'(timeout), 32'd0);
        check("to_done_idx", 32'(gnt_idx), 32'd0);
        step(8'h00, 1'b1);
`endif

        for (int c = 0; c < 400; c++) begin
            step(N'($urandom) & N'($urandom), ($urandom_range(0, 2) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
